sgx_enclave_seq: RTL and testbench

Enclave command sequencer sitting directly upstream of the SGX enclave controller. Accepts enclave lifecycle commands over a valid/ready interface and enforces legal ordering (ECREATE → EADD* → EINIT → EENTER/EEXIT, plus EREMOVE teardown). Issues single-cycle command pulses with registered address and data to the controller. Maintains the page count and a running 64-bit enclave measurement that freezes at EINIT.

---
 rtl/sgx_enclave_seq_if.sv | 31 +++
 rtl/sgx_enclave_seq.sv | 152 +++++++++++++++
 tb/tb_sgx_enclave_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sgx_enclave_seq_if.sv
// sgx_enclave_seq_if: command request / response bundle of the
// enclave sequencer (valid/ready in, completion strobe out).
interface sgx_enclave_seq_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [63:0] cmd_addr_i;
    logic [63:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;

    modport master (
        output cmd_valid_i,
        output cmd_op_i,
        output cmd_addr_i,
        output cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o,
        input  rsp_err_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_op_i,
        input  cmd_addr_i,
        input  cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o,
        output rsp_err_o
    );
endinterface

// File: rtl/sgx_enclave_seq.sv
// sgx_enclave_seq: orders enclave lifecycle commands, drives one-cycle
// controller pulses and keeps the page count and running measurement.
module sgx_enclave_seq #(
    parameter int MAX_PAGES = 256,
    parameter int CNT_W     = $clog2(MAX_PAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sgx_enclave_seq_if.slave cmd,
    output logic             ecreate_o,
    output logic             eadd_o,
    output logic             einit_o,
    output logic             eenter_o,
    output logic             eexit_o,
    output logic [63:0]      addr_o,
    output logic [63:0]      wdata_o,
    output logic [63:0]      mrenclave_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] page_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CREATED = 3'd1,
        S_MEAS    = 3'd2,
        S_INIT    = 3'd3,
        S_ACTIVE  = 3'd4
    } state_e;

    localparam logic [2:0] OP_ECREATE = 3'd0;
    localparam logic [2:0] OP_EADD    = 3'd1;
    localparam logic [2:0] OP_EINIT   = 3'd2;
    localparam logic [2:0] OP_EENTER  = 3'd3;
    localparam logic [2:0] OP_EEXIT   = 3'd4;
    localparam logic [2:0] OP_EREMOVE = 3'd5;

    localparam logic [63:0] MR_SEED = 64'h5347_5845_4E43_4C56;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAGES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    // pulse vector bit order: ecreate, eadd, einit, eenter, eexit
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mr_q, mr_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [4:0]       pulse_q, pulse_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             accept;
    logic [2:0]       op;

    assign cmd.cmd_ready_o = (state_q != S_MEAS);
    assign accept = cmd.cmd_valid_i & cmd.cmd_ready_o;
    assign op     = cmd.cmd_op_i;

    // next-state, measurement, counter and pulse decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mr_d        = mr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pulse_d     = 5'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (state_q == S_MEAS) begin
            // fold the page just added, then complete the EADD
            mr_d = {mr_q[56:0], mr_q[63:57]}
                 ^ addr_q
                 ^ {wdata_q[31:0], wdata_q[63:32]};
            state_d     = S_CREATED;
            rsp_valid_d = 1'b1;
        end else if (accept) begin
            addr_d      = cmd.cmd_addr_i;
            wdata_d     = cmd.cmd_wdata_i;
            rsp_valid_d = 1'b1;
            unique case (1'b1)
                (state_q == S_IDLE) && (op == OP_ECREATE): begin
                    pulse_d = 5'b10000;
                    state_d = S_CREATED;
                    cnt_d   = ONE_CNT;
                    mr_d    = cmd.cmd_addr_i ^ MR_SEED;
                end
                (state_q == S_CREATED) && (op == OP_EADD)
                    && (cnt_q < MAX_CNT): begin
                    pulse_d     = 5'b01000;
                    state_d     = S_MEAS;
                    cnt_d       = cnt_q + ONE_CNT;
                    rsp_valid_d = 1'b0;
                end
                (state_q == S_CREATED) && (op == OP_EINIT): begin
                    pulse_d = 5'b00100;
                    state_d = S_INIT;
                end
                (state_q == S_INIT) && (op == OP_EENTER): begin
                    pulse_d = 5'b00010;
                    state_d = S_ACTIVE;
                end
                (state_q == S_ACTIVE) && (op == OP_EEXIT): begin
                    pulse_d = 5'b00001;
                    state_d = S_INIT;
                end
                (state_q == S_INIT) && (op == OP_EREMOVE): begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    mr_d    = '0;
                end
                default: begin
                    rsp_err_d = 1'b1;
                end
            endcase
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mr_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pulse_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mr_q        <= mr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pulse_q     <= pulse_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ecreate_o       = pulse_q[4];
    assign eadd_o          = pulse_q[3];
    assign einit_o         = pulse_q[2];
    assign eenter_o        = pulse_q[1];
    assign eexit_o         = pulse_q[0];
    assign addr_o          = addr_q;
    assign wdata_o         = wdata_q;
    assign mrenclave_o     = mr_q;
    assign state_o         = state_q;
    assign page_cnt_o      = cnt_q;
    assign cmd.rsp_valid_o = rsp_valid_q;
    assign cmd.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_sgx_enclave_seq.sv
// tb_sgx_enclave_seq: directed and random command streams checked
// against a command-level model of the enclave lifecycle.
module tb_sgx_enclave_seq;

    localparam int MAXP = 4;
    localparam int CW   = $clog2(MAXP + 1);
    localparam logic [63:0] K = 64'h5347_5845_4E43_4C56;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sgx_enclave_seq_if bus ();

    logic          ecreate, eadd, einit, eenter, eexit;
    logic [63:0]   addr_o, wdata_o, mr_o;
    logic [2:0]    st_o;
    logic [CW-1:0] cnt_o;
    logic [4:0]    pulses;

    assign pulses = {ecreate, eadd, einit, eenter, eexit};

    sgx_enclave_seq #(.MAX_PAGES(MAXP)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (bus.slave),
        .ecreate_o   (ecreate),
        .eadd_o      (eadd),
        .einit_o     (einit),
        .eenter_o    (eenter),
        .eexit_o     (eexit),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .mrenclave_o (mr_o),
        .state_o     (st_o),
        .page_cnt_o  (cnt_o)
    );

    int errors = 0;
    int checks = 0;

    // model: lifecycle state (0 idle,1 created,3 init,4 active)
    int          m_st;
    int          m_cnt;
    logic [63:0] m_mr;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_cnt = 0;
        m_mr  = '0;
    endtask

    task automatic idle();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pulses"}, {59'd0, pulses}, 0);
        chk({tag, "_rspv"}, {63'd0, bus.rsp_valid_o}, 0);
        chk({tag, "_rspe"}, {63'd0, bus.rsp_err_o}, 0);
        chk({tag, "_addr"}, addr_o, 0);
        chk({tag, "_wdata"}, wdata_o, 0);
        chk({tag, "_mr"}, mr_o, 0);
        chk({tag, "_cnt"}, {{(64-CW){1'b0}}, cnt_o}, 0);
        chk({tag, "_state"}, {61'd0, st_o}, 0);
    endtask

    // issue one command (inputs set 1 time unit after an edge)
    task automatic do_cmd(input logic [2:0] op,
                          input logic [63:0] a,
                          input logic [63:0] w);
        logic [4:0] exp_p;
        logic       exp_err;
        logic       is_add;
        exp_p   = '0;
        exp_err = 1'b0;
        is_add  = 1'b0;
        if (m_st == 0 && op == 3'd0) begin
            exp_p = 5'b10000;
            m_st  = 1;
            m_cnt = 1;
            m_mr  = a ^ K;
        end else if (m_st == 1 && op == 3'd1 && m_cnt < MAXP) begin
            exp_p  = 5'b01000;
            is_add = 1'b1;
            m_cnt++;
            m_mr = {m_mr[56:0], m_mr[63:57]} ^ a ^ {w[31:0], w[63:32]};
        end else if (m_st == 1 && op == 3'd2) begin
            exp_p = 5'b00100;
            m_st  = 3;
        end else if (m_st == 3 && op == 3'd3) begin
            exp_p = 5'b00010;
            m_st  = 4;
        end else if (m_st == 4 && op == 3'd4) begin
            exp_p = 5'b00001;
            m_st  = 3;
        end else if (m_st == 3 && op == 3'd5) begin
            m_st  = 0;
            m_cnt = 0;
            m_mr  = '0;
        end else begin
            exp_err = 1'b1;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = w;
        chk("ready_pre", {63'd0, bus.cmd_ready_o}, 1);
        @(posedge clk);
        #1;
        if (is_add) begin
            chk("meas_pulse", {59'd0, pulses}, {59'd0, exp_p});
            chk("meas_state", {61'd0, st_o}, 2);
            chk("meas_ready", {63'd0, bus.cmd_ready_o}, 0);
            chk("meas_rspv", {63'd0, bus.rsp_valid_o}, 0);
            chk("meas_addr", addr_o, a);
            chk("meas_wdata", wdata_o, w);
            @(posedge clk);
            #1;
            chk("add_nopulse", {59'd0, pulses}, 0);
        end else begin
            chk("pulse", {59'd0, pulses}, {59'd0, exp_p});
            if (exp_p != 5'b0) chk("addr", addr_o, a);
        end
        chk("rspv", {63'd0, bus.rsp_valid_o}, 1);
        chk("rspe", {63'd0, bus.rsp_err_o}, {63'd0, exp_err});
        chk("state", {61'd0, st_o}, m_st);
        chk("cnt", {{(64-CW){1'b0}}, cnt_o}, m_cnt);
        chk("mr", mr_o, m_mr);
        chk("ready_post", {63'd0, bus.cmd_ready_o}, 1);
    endtask

    initial begin
        logic [63:0] mr_frozen;
        rst             = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_addr_i  = 64'h100;
        bus.cmd_wdata_i = 64'h55;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        chk_reset_vals("rst");
        chk("rst_ready", {63'd0, bus.cmd_ready_o}, 1);
        @(posedge clk);
        #1;
        chk("idle_rspv", {63'd0, bus.rsp_valid_o}, 0);

        do_cmd(3'd0, 64'h100, 64'h0);
        chk("create_mr", mr_o, 64'h5347_5845_4E43_4D56);
        do_cmd(3'd1, 64'h200, 64'h1111_2222_3333_4444);
        do_cmd(3'd1, 64'h300, 64'hDEAD_BEEF_0123_4567);
        do_cmd(3'd1, 64'h400, 64'hFFFF_0000_A5A5_5A5A);
        do_cmd(3'd1, 64'h500, 64'h1);
        chk("full_cnt", {{(64-CW){1'b0}}, cnt_o}, 4);
        do_cmd(3'd2, 64'h600, 64'h0);
        mr_frozen = mr_o;
        do_cmd(3'd3, 64'h700, 64'h0);
        do_cmd(3'd4, 64'h800, 64'h0);
        do_cmd(3'd3, 64'h900, 64'h0);
        chk("frozen_mr", mr_o, mr_frozen);
        chk("active_state", {61'd0, st_o}, 4);

        do_cmd(3'd0, 64'hA00, 64'h0);
        do_cmd(3'd7, 64'hB00, 64'h0);
        do_cmd(3'd4, 64'hC00, 64'h0);
        do_cmd(3'd1, 64'hD00, 64'h2);
        do_cmd(3'd5, 64'hE00, 64'h0);
        do_cmd(3'd3, 64'hF00, 64'h0);
        idle();

        do_cmd(3'd0, 64'h1234, 64'h0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd1;
        bus.cmd_addr_i  = 64'h2000;
        bus.cmd_wdata_i = 64'h77;
        @(posedge clk);
        #1;
        chk("rstm_eadd", {63'd0, eadd}, 1);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        chk_reset_vals("rstm");
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rstm_norsp", {63'd0, bus.rsp_valid_o}, 0);
        chk("rstm_state", {61'd0, st_o}, 0);

        for (int i = 0; i < 150; i++) begin
            do_cmd(3'($urandom_range(0, 7)),
                   {$urandom, $urandom},
                   {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
                chk("rnd_idle_rspv", {63'd0, bus.rsp_valid_o}, 0);
            end
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
